// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider that owns HI/LO.
// Define MULDIV_DIV_EN to build the divider; without it DIV/DIVU are accepted as no-ops.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             rd_hilo,
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
      DIV  = 2'd2,
`endif
      FIX  = 2'd3
   } state_t;

   state_t             state_reg, state_next;
   logic [CW-1:0]      cnt_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0]   opnd_reg, hi_reg, lo_reg;
   logic               neg_q_reg;
   logic [WIDTH-1:0]   mag_a, mag_b, ua, ub, load_opnd, mul_addend, fix_hi, fix_lo;
   logic [2*WIDTH-1:0] load_acc, mul_step, prod_signed;
   logic [WIDTH:0]     mul_sum;
`ifdef MULDIV_DIV_EN
   logic               neg_r_reg, is_div_reg, div_ge;
   logic [WIDTH:0]     div_part;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_step;
`endif

   assign busy  = (state_reg != IDLE);
   assign stall = busy & (start | rd_hilo);
   assign hi    = hi_reg;
   assign lo    = lo_reg;

   assign mag_a = a[WIDTH-1] ? -a : a;
   assign mag_b = b[WIDTH-1] ? -b : b;

   // Operands are latched as magnitudes for signed ops; sign is reapplied in FIX.
   always_comb begin
      ua        = op[0] ? a : mag_a;
      ub        = op[0] ? b : mag_b;
      load_acc  = {{WIDTH{1'b0}}, ub};
      load_opnd = ua;
`ifdef MULDIV_DIV_EN
      if (op[1]) begin
         load_acc  = {{WIDTH{1'b0}}, ua};
         load_opnd = ub;
      end
`endif
   end

   assign mul_addend  = acc_reg[0] ? opnd_reg : '0;
   assign mul_sum     = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
   assign mul_step    = {mul_sum, acc_reg[WIDTH-1:1]};
   assign prod_signed = neg_q_reg ? ('0 - acc_reg) : acc_reg;

`ifdef MULDIV_DIV_EN
   // Restoring step; a zero divisor naturally yields all-ones quotient and remainder |a|.
   assign div_part = acc_reg[2*WIDTH-1:WIDTH-1];
   assign div_ge   = (div_part >= {1'b0, opnd_reg});
   assign div_rem  = div_part[WIDTH-1:0] - opnd_reg;
   assign div_step = div_ge ? {div_rem, acc_reg[WIDTH-2:0], 1'b1}
                            : {div_part[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
`endif

   always_comb begin
      {fix_hi, fix_lo} = prod_signed;
`ifdef MULDIV_DIV_EN
      if (is_div_reg) begin
         fix_lo = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
         fix_hi = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (op == OP_MULT || op == OP_MULTU) state_next = MUL;
`ifdef MULDIV_DIV_EN
               else if (op == OP_DIV || op == OP_DIVU) state_next = DIV;
`endif
            end
         end
         MUL:     if (cnt_reg == LAST_ITER) state_next = FIX;
`ifdef MULDIV_DIV_EN
         DIV:     if (cnt_reg == LAST_ITER) state_next = FIX;
`endif
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg   <= '0;
         acc_reg   <= '0;
         opnd_reg  <= '0;
         neg_q_reg <= 1'b0;
         hi_reg    <= '0;
         lo_reg    <= '0;
`ifdef MULDIV_DIV_EN
         neg_r_reg  <= 1'b0;
         is_div_reg <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               cnt_reg <= '0;
               if (start) begin
                  acc_reg   <= load_acc;
                  opnd_reg  <= load_opnd;
                  neg_q_reg <= ~op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
                  is_div_reg <= op[1];
                  neg_r_reg  <= ~op[0] & a[WIDTH-1];
`endif
                  if (op == OP_MTHI) hi_reg <= a;
                  if (op == OP_MTLO) lo_reg <= a;
               end
            end
            MUL: begin
               acc_reg <= mul_step;
               cnt_reg <= cnt_reg + CW'(1);
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
               acc_reg <= div_step;
               cnt_reg <= cnt_reg + CW'(1);
            end
`endif
            FIX: begin
               hi_reg <= fix_hi;
               lo_reg <= fix_lo;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus queues expected {HI,LO}; a monitor pops on
// each completion (busy falling, or the cycle after an immediate op is accepted).
module tb_muldiv_unit;
   localparam int W = 32;
   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_RSV6  = 3'b110;
   localparam logic [2:0] OP_RSV7  = 3'b111;

   logic         clk = 1'b0;
   logic         reset, start, rd_hilo;
   logic [2:0]   op;
   logic [W-1:0] a, b;
   logic         busy, stall;
   logic [W-1:0] hi, lo;

   int vectors = 0;
   int miscompares = 0;
   logic [2*W-1:0] sb_q[$];
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .rd_hilo(rd_hilo), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   function automatic bit is_imm(input logic [2:0] o);
`ifdef MULDIV_DIV_EN
      return o[2];
`else
      return o[2] || o[1];
`endif
   endfunction

   // Monitor
   initial begin
      bit pend;
      bit busy_prev;
      int busy_cnt;
      logic [2*W-1:0] e;
      pend = 0; busy_prev = 0; busy_cnt = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pend = 0; busy_prev = 0; busy_cnt = 0;
         end else begin
            if (pend) begin
               chk("imm_busy", busy, 0);
               if (sb_q.size() == 0) chk("sb_nonempty", 0, 1);
               else begin
                  e = sb_q.pop_front();
                  chk("imm_hi", hi, e[2*W-1:W]);
                  chk("imm_lo", lo, e[W-1:0]);
               end
               pend = 0;
            end
            if (busy) busy_cnt++;
            else if (busy_prev) begin
               chk("busy_cycles", busy_cnt, W + 1);
               if (sb_q.size() == 0) chk("sb_nonempty", 0, 1);
               else begin
                  e = sb_q.pop_front();
                  chk("res_hi", hi, e[2*W-1:W]);
                  chk("res_lo", lo, e[W-1:0]);
               end
               busy_cnt = 0;
            end
            busy_prev = busy;
            if (start && !busy && is_imm(op)) pend = 1;
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] eh, input logic [W-1:0] el, output int waited);
      bit ok;
      start = 1; op = o; a = x; b = y;
      m_hi = eh; m_lo = el;
      sb_q.push_back({eh, el});
      waited = 0; ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk); ok = !busy && !reset;
         @(posedge clk); #1; waited++;
      end
      start = 0;
      if (!ok) begin
         vectors++; miscompares++;
         $display("FAIL accept: op %0d not accepted within 200 cycles", o);
      end
   endtask

   task automatic drain();
      int i;
      i = 0;
      while ((sb_q.size() != 0 || busy) && i < 200) begin
         @(posedge clk); #1; i++;
      end
      chk("drain_done", (i < 200), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      reset = 1; start = 1; op = OP_MULT; a = 5; b = 5; rd_hilo = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_stall", stall, 0);
      chk("reset_hi", hi, 0);
      chk("reset_lo", lo, 0);
      start = 0; rd_hilo = 0;
      @(posedge clk); #1;
      reset = 0;

      issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, w);
      chk("multu_wait", w, 1);
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, w);
      chk("held_wait", w, W + 2);
      rd_hilo = 1;
      for (int k = 0; k < W + 1; k++) begin
         @(negedge clk); chk("mfhi_stall", stall, 1);
      end
      @(negedge clk);
      chk("mfhi_release", stall, 0);
      chk("mfhi_hi", hi, 32'hFFFF_FFFF);
      chk("mfhi_lo", lo, 32'hFFFF_FFEB);
      @(posedge clk); #1;
      rd_hilo = 0;

      issue(OP_MTHI, 32'h1234_5678, 32'd0, 32'h1234_5678, m_lo, w);
      issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0, m_hi, 32'h9ABC_DEF0, w);
      chk("mtlo_wait", w, 1);
      issue(OP_RSV6, 32'hDEAD_BEEF, 32'd1, m_hi, m_lo, w);
      issue(OP_RSV7, 32'h0000_0001, 32'd1, m_hi, m_lo, w);

      issue(OP_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, w);
      issue(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, w);
      chk("b2b_wait", w, W + 2);
      issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, w);

`ifdef MULDIV_DIV_EN
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, w);
      issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, w);
      issue(OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, w);
      issue(OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1, w);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, w);
      issue(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, w);
      drain();
      issue(OP_DIV, 32'd1000, 32'd3, 32'd1, 32'd333, w);
`else
      issue(OP_DIVU, 32'd9, 32'd3, m_hi, m_lo, w);
      drain();
      issue(OP_MULTU, 32'd1000, 32'd3, 32'd0, 32'd3000, w);
`endif
      repeat (9) begin
         @(posedge clk); #1;
      end
      reset = 1;
      @(posedge clk); #1;
      reset = 0;
      sb_q.delete();
      m_hi = '0; m_lo = '0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_hi", hi, 0);
      chk("abort_lo", lo, 0);
      @(posedge clk); #1;
      issue(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, w);
      chk("post_reset_wait", w, 1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit owning the architectural HI/LO registers of the pipelined MIPS core. It sits beside the execute stage: execute issues MULT/MULTU/DIV/DIVU/MTHI/MTLO, and reads HI/LO for MFHI/MFLO. The unit drives the stall term that feeds the core-wide `AnyStall` while a multi-cycle operation is in flight.

## Interface
- `WIDTH`, 32, operand and HI/LO width; must be ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  execute presents a muldiv op this cycle.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved, treated as no-op.
- `a`  in  WIDTH  rs operand; dividend/multiplicand; MTHI/MTLO source.
- `b`  in  WIDTH  rt operand; divisor/multiplier.
- `rd_hilo`  in  1  execute instruction is MFHI/MFLO this cycle.
- `busy`  out  1  multi-cycle op in progress.
- `stall`  out  1  `busy & (start | rd_hilo)`; combinational.
- `hi`, `lo`  out  WIDTH  architectural HI/LO; registered.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Acceptance: `start & ~busy` at a rising edge. When busy, `start` is not accepted; `stall` holds execute so the op is re-presented.
- MTHI/MTLO: on acceptance, writes `a` into HI/LO. State stays IDLE and `busy` stays 0.
- MULT/MULTU: latch magnitudes (`|a|`, `|b|` for MULT; raw for MULTU), then go to MUL.
  - MUL runs WIDTH shift-add iterations using a 2·WIDTH accumulator and a 5-bit (log2 WIDTH) counter.
  - Then go to FIX. FIX negates the 2·WIDTH product if signed and `a[W-1]^b[W-1]`.
  - Write `{HI,LO}` = product; return to IDLE.
- DIV/DIVU: latch magnitudes, then go to DIV. DIV runs WIDTH restoring-division iterations.
  - Then go to FIX. Signed: quotient negated if `a`/`b` signs differ; remainder takes the sign of `a`.
  - LO = quotient, HI = remainder.
- Divide by zero, deterministic:
  - HI = `a`.
  - DIVU: LO = all-ones.
  - DIV: LO = all-ones if `a` ≥ 0, else 1.
- Overflow: DIV of 0x80000000 by 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- HI/LO are never partially updated; both change only on the FIX→IDLE edge, or singly via MTHI/MTLO.
- Reserved ops are accepted with no effect.
- Reset at any point: state IDLE, counter 0, HI = LO = 0, `busy` = 0; an in-flight op is discarded.

## Timing
- Reset values: `busy` 0, `stall` 0, `hi` 0, `lo` 0.
- Op accepted at edge T:
  - `busy` = 1 for cycles T+1 … T+WIDTH+1 (WIDTH iterations + 1 FIX).
  - HI/LO update at edge T+WIDTH+1.
  - `busy` = 0 from cycle T+WIDTH+2. With WIDTH=32: 33 busy cycles.
- MTHI/MTLO: HI/LO valid the cycle after acceptance, zero stall.
- MFHI/MFLO during the last busy cycle still stalls. The read completes the cycle `busy` drops and returns the new value.
- Back-to-back: a `start` held under stall is accepted on the first edge where `busy` = 0. There is no idle bubble between ops beyond that.
- `start` with `op` = MTHI/MTLO while busy also stalls. This enforces ordering with the in-flight result.

## Configuration
- `MULDIV_DIV_EN` defined: DIV/DIVU supported as above.
- `MULDIV_DIV_EN` undefined: divider datapath and DIV state are not built. DIV/DIVU are accepted like reserved ops: no busy, HI/LO unchanged. MULT/MULTU/MTHI/MTLO are unaffected.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `busy` for exactly 33 cycles; HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (−3), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. `rd_hilo` held from T+1 → `stall`=1 until `busy` falls.
- DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=100, b=0 → LO=0xFFFFFFFF, HI=100. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles → `busy` never asserts; `hi`/`lo` match one cycle after each.
- MULT issued, second `start` (MULTU 3×5) held during busy → second op accepted the first cycle `busy`=0; final HI=0, LO=15.
- Reset asserted at iteration 10 of a DIV → next cycle `busy`=0, `hi`=`lo`=0; a subsequent MULTU 2×3 yields LO=6. With `MULDIV_DIV_EN` undefined, DIVU 9/3 leaves HI/LO unchanged and `busy`=0.
